serial_normalizer: RTL and testbench
====================================

SERIAL_NORMALIZER -- requirements
Module: serial_normalizer

Interface
- REQ-001 The block SHALL have parameter BW, default 8, giving the data width in bits; legal values are BW >= 2.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
- REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
- REQ-006 The block SHALL have port in_data, input, BW bits: the word to normalize.
- REQ-007 The block SHALL have port out_valid, output, 1 bit: the result is valid.
- REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
- REQ-009 The block SHALL have port out_data, output, BW bits: the normalized word, with MSB set unless the input was zero.
- REQ-010 The block SHALL have port out_shift, output, $clog2(BW) bits: the leading-zero count applied, in the same encoding as a left-shifter shift_amt.
- REQ-011 The block SHALL have port out_zero, output, 1 bit: the accepted word was all zeros.

Function
- REQ-012 The block SHALL implement an FSM with three states: IDLE, NORM and DONE.
- REQ-013 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in_ready SHALL be 0 in NORM and DONE, with no bypass path.
- REQ-014 On an edge with in_valid=1 in IDLE, the block SHALL load in_data into a work register, clear the shift counter and out_zero, and enter NORM.
- REQ-015 On each edge in NORM, exactly one action SHALL occur, in this priority order:
  - work register == 0: set out_zero=1, force the counter to 0, enter DONE;
  - work register MSB == 1: enter DONE;
  - otherwise: shift the work register left by 1 with zero fill, and increment the counter.
- REQ-016 A nonzero word with k leading zeros (0 <= k <= BW-1) SHALL raise out_valid exactly k+1 edges after the accept edge; a zero word SHALL raise it exactly 1 edge after.
- REQ-017 The counter SHALL never exceed BW-1, and no wrap-around SHALL be possible.
- REQ-018 In DONE, out_valid SHALL be 1, and out_data, out_shift and out_zero SHALL stay stable until the handshake completes.
- REQ-019 On an edge in DONE with out_ready=1, the block SHALL return to IDLE; the next word SHALL be accepted no earlier than the following edge.
- REQ-020 The block SHALL hold the invariant out_data == (accepted in_data << out_shift) truncated to BW bits, and out_data[BW-1]==1 whenever out_zero==0.
- REQ-021 Outside DONE, out_data, out_shift and out_zero SHALL read 0.
- REQ-022 in_data and in_valid SHALL be ignored outside IDLE; a word presented while busy SHALL NOT be captured or lost-accepted.
- REQ-023 Back-to-back throughput SHALL be one word per k+3 cycles, with no overlap between words.

Reset
- REQ-024 With rst=1 at an edge, the block SHALL enter IDLE, clear the work register and counter, and drive in_ready=1, out_valid=0, out_data=0, out_shift=0 and out_zero=0 after that edge.
- REQ-025 Reset SHALL take priority over every handshake and FSM transition, including mid-NORM and mid-DONE; any in-flight word SHALL be discarded with no out_valid pulse.
- REQ-026 The first legal accept after reset SHALL be the first edge with rst=0.

Verification (BW=8, out_ready=1 unless stated)
- REQ-027 The bench SHALL cover: accept 0x80 -> out_valid 1 edge later; out_data=0x80, out_shift=0, out_zero=0.
- REQ-028 The bench SHALL cover: accept 0x13 -> out_valid 4 edges later; out_data=0x98, out_shift=3.
- REQ-029 The bench SHALL cover: accept 0x01 -> out_valid 8 edges later; out_data=0x80, out_shift=7; and accept 0x00 -> out_valid 1 edge later; out_zero=1, out_data=0x00, out_shift=0.
- REQ-030 The bench SHALL cover: accept 0x05, hold out_ready=0 for 5 cycles in DONE, while presenting in_valid=1 with in_data=0xFF -> in_ready stays 0; out_data=0xA0 and out_shift=5 stay stable; 0xFF is accepted only after return to IDLE.
- REQ-031 The bench SHALL cover: assert rst 2 edges after accepting 0x01 -> IDLE after that edge; all outputs 0; in_ready=1; no out_valid ever produced for 0x01.
- REQ-032 The bench SHALL cover: 1000 random words with random in_valid/out_ready throttling -> every result satisfies REQ-020 and REQ-016, and results come out in acceptance order.

Source files
------------

// File: rtl/serial_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_normalizer
//  Purpose  : Iterative leading-zero normalizer. A word accepted in IDLE is
//             shifted left one bit per cycle until its MSB is set (or it is
//             found to be zero), then held in DONE until it is taken.
//  Ports    :
//    clk        - single clock, all state updates on its rising edge
//    rst        - synchronous active-high reset
//    in_valid   - upstream word valid
//    in_ready   - block can accept a word (IDLE only)
//    in_data    - word to normalize (BW bits)
//    out_valid  - result valid (DONE only)
//    out_ready  - downstream accepts the result
//    out_data   - normalized word, MSB set unless the input was zero
//    out_shift  - leading-zero count applied ($clog2(BW) bits)
//    out_zero   - the accepted word was all zeros
//  Revision : 1.0 - initial release
// ============================================================================
module serial_normalizer #(
   parameter int BW = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BW-1:0]         in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BW-1:0]         out_data,
   output logic [$clog2(BW)-1:0] out_shift,
   output logic                  out_zero
);

   localparam int SW = $clog2(BW);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   work_q,  work_d;
   logic [SW-1:0]   cnt_q,   cnt_d;
   logic            zero_q,  zero_d;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      zero_d    = zero_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_shift = '0;
      out_zero  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               work_d  = in_data;
               cnt_d   = '0;
               zero_d  = 1'b0;
               state_d = ST_NORM;
            end
         end

         ST_NORM: begin
            // Zero test comes first so an all-zero word never shifts and the
            // counter stays at 0. A nonzero word reaches MSB=1 after at most
            // BW-1 shifts, so the counter is bounded by BW-1 and cannot wrap.
            if (work_q == '0) begin
               zero_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_DONE;
            end else if (work_q[BW-1]) begin
               state_d = ST_DONE;
            end else begin
               work_d = {work_q[BW-2:0], 1'b0};
               cnt_d  = cnt_q + SW'(1);
            end
         end

         ST_DONE: begin
            // Results are only exposed here; they read 0 in every other state.
            out_valid = 1'b1;
            out_data  = work_q;
            out_shift = cnt_q;
            out_zero  = zero_q;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_normalizer
//  Purpose  : Self-checking bench for serial_normalizer (BW=8): directed
//             vectors with hand-computed results, busy/backpressure, reset
//             abort, and a throttled random stream against a small model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_normalizer;

   localparam int BW = 8;
   localparam int SW = $clog2(BW);

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic [SW-1:0] out_shift;
   logic          out_zero;

   int n_chk  = 0;
   int n_pass = 0;

   serial_normalizer #(.BW(BW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_shift (out_shift),
      .out_zero  (out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: leading-zero count of a nonzero word
   function automatic int lz(input logic [BW-1:0] d);
      int k;
      k = 0;
      for (int i = BW - 1; i >= 0; i--) begin
         if (d[i]) return k;
         k++;
      end
      return 0;
   endfunction

   // Directed single word with out_ready held at 1
   task automatic run_word(input string tag, input logic [7:0] d, input logic [7:0] exp_d,
                           input int exp_sh, input logic exp_z, input int exp_lat);
      int lat;
      chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      chk({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy_data"}, 32'(out_data), 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
      chk({tag, "_shift"}, 32'(out_shift), 32'(exp_sh));
      chk({tag, "_zero"}, 32'(out_zero), 32'(exp_z));
      tick();
      chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin : main
      int lat;
      int cyc;
      int nw;
      logic seen_v;
      logic acc;
      logic hs;
      logic prev_v;
      logic [7:0] tmp;
      logic [7:0] q[$];
      int acc_cyc[$];

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_shift", 32'(out_shift), 32'd0);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      rst = 1'b0;
      tick();

      // Directed vectors (hand-computed)
      run_word("w80", 8'h80, 8'h80, 0, 1'b0, 1);
      run_word("w13", 8'h13, 8'h98, 3, 1'b0, 4);
      run_word("w01", 8'h01, 8'h80, 7, 1'b0, 8);
      run_word("w00", 8'h00, 8'h00, 0, 1'b1, 1);
      run_word("w3c", 8'h3C, 8'hF0, 2, 1'b0, 3);

      // Backpressure in DONE with a competing word presented
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h05;
      tick();
      in_data   = 8'hFF;
      chk("bp_busy_rdy", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("bp_lat", 32'(lat), 32'd6);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_rdy", 32'(in_ready), 32'd0);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_data", 32'(out_data), 32'hA0);
         chk("bp_hold_shift", 32'(out_shift), 32'd5);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_back_idle", 32'(in_ready), 32'd1);
      chk("bp_back_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("bp_ff_accepted", 32'(in_ready), 32'd0);
      tick();
      chk("bp_ff_valid", 32'(out_valid), 32'd1);
      chk("bp_ff_data", 32'(out_data), 32'hFF);
      chk("bp_ff_shift", 32'(out_shift), 32'd0);
      tick();

      // Reset abort mid-NORM: no result may ever appear for 0x01
      in_valid = 1'b1;
      in_data  = 8'h01;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_data", 32'(out_data), 32'd0);
      chk("abort_out_shift", 32'(out_shift), 32'd0);
      chk("abort_out_zero", 32'(out_zero), 32'd0);
      rst    = 1'b0;
      seen_v = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen_v = 1'b1;
      end
      chk("abort_no_valid", 32'(seen_v), 32'd0);

      // First edge with rst=0 accepts
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h40;
      tick();
      in_valid = 1'b0;
      chk("post_rst_accept", 32'(in_ready), 32'd0);
      tick();
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_data", 32'(out_data), 32'h80);
      chk("post_rst_shift", 32'(out_shift), 32'd1);
      tick();

      // Throttled random stream
      cyc    = 0;
      nw     = 0;
      prev_v = out_valid;
      while (nw < 1000 && cyc < 60000) begin
         tmp       = 8'($urandom);
         in_valid  = ($urandom_range(0, 1) == 1);
         in_data   = tmp >> $urandom_range(0, 8);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         if (hs) begin
            if (q.size() == 0) begin
               chk("rnd_spurious_hs", 32'd1, 32'd0);
            end else begin
               chk("rnd_data", 32'(out_data), 32'((q[0] << lz(q[0])) & 8'hFF));
               chk("rnd_shift", 32'(out_shift), (q[0] == 8'h00) ? 32'd0 : 32'(lz(q[0])));
               chk("rnd_zero", 32'(out_zero), 32'(q[0] == 8'h00));
               void'(q.pop_front());
               void'(acc_cyc.pop_front());
            end
            nw++;
         end
         tmp = in_data;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            q.push_back(tmp);
            acc_cyc.push_back(cyc);
         end
         if (out_valid && !prev_v) begin
            if (q.size() == 0) begin
               chk("rnd_spurious_valid", 32'd1, 32'd0);
            end else begin
               chk("rnd_lat", 32'(cyc - acc_cyc[0]),
                   (q[0] == 8'h00) ? 32'd1 : 32'(lz(q[0]) + 1));
            end
         end
         prev_v = out_valid;
      end
      chk("rnd_words_done", 32'(nw), 32'd1000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
